// File: rtl/video_pkg.sv
// Shared definitions for the video subsystem: default VRAM geometry and the
// VRAM arbiter state encoding.
package video_pkg;

    localparam int VRAM_ADDR_W = 14;
    localparam int VRAM_DATA_W = 16;
    localparam int LINE_WORDS  = 80;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FETCH     = 2'd1,
        ST_CPU_ISSUE = 2'd2,
        ST_CPU_ACK   = 2'd3
    } vram_arb_state_t;

endpackage

// File: rtl/vram_arbiter.sv
// Arbitrates the single-port VRAM between scanline fetch (priority) and the
// CPU bus bridge, with forced CPU slots between fetch bursts.
module vram_arbiter
    import video_pkg::*;
#(
    parameter int ADDR_W    = VRAM_ADDR_W,
    parameter int DATA_W    = VRAM_DATA_W,
    parameter int FETCH_LEN = LINE_WORDS,
    parameter int BURST     = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         line_start,
    input  logic [ADDR_W-1:0]            line_base,
    output logic                         fetch_wr_en,
    output logic [$clog2(FETCH_LEN)-1:0] fetch_wr_idx,
    output logic [DATA_W-1:0]            fetch_wr_data,
    output logic                         fetch_done,
    output logic                         fetch_overrun,
    input  logic                         cpu_req,
    input  logic                         cpu_we,
    input  logic [ADDR_W-1:0]            cpu_addr,
    input  logic [DATA_W-1:0]            cpu_wdata,
    input  logic [1:0]                   cpu_be,
    output logic                         cpu_ack,
    output logic [DATA_W-1:0]            cpu_rdata,
    output logic                         mem_cs,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    output logic [3:0]                   mem_maskwe,
    input  logic [DATA_W-1:0]            mem_rdata
);

    localparam int IDX_W  = $clog2(FETCH_LEN);
    localparam int BCNT_W = $clog2(BURST + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FETCH_LEN - 1);
    localparam logic [BCNT_W-1:0] BURST_C  = BCNT_W'(BURST);
    localparam logic [BCNT_W-1:0] BURST_M1 = BCNT_W'(BURST - 1);

    vram_arb_state_t   state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] pend_base_q, pend_base_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [BCNT_W-1:0] burst_q, burst_d;
    logic              armed_q, armed_d;
    logic              pend_q, pend_d;
    logic              resume_q, resume_d;
    logic              wr_valid_q, wr_last_q;
    logic [IDX_W-1:0]  wr_idx_q;

    logic cpu_pending;
    logic fetch_busy;
    logic in_fetch;
    logic in_issue;

    assign in_fetch    = (state_q == ST_FETCH);
    assign in_issue    = (state_q == ST_CPU_ISSUE);
    assign cpu_pending = cpu_req && armed_q;
    assign fetch_busy  = in_fetch || resume_q;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        pend_base_d = pend_base_q;
        idx_d       = idx_q;
        burst_d     = burst_q;
        pend_d      = pend_q;
        resume_d    = resume_q;

        // Re-arm only once the request has been seen low, so a request still
        // held through its ack cycle is not serviced a second time.
        if (state_q == ST_CPU_ACK) begin
            armed_d = 1'b0;
        end else if (!cpu_req) begin
            armed_d = 1'b1;
        end else begin
            armed_d = armed_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (line_start) begin
                    state_d = ST_FETCH;
                    base_d  = line_base;
                    idx_d   = '0;
                    burst_d = '0;
                end else if (cpu_pending) begin
                    state_d = ST_CPU_ISSUE;
                end
            end
            ST_FETCH: begin
                idx_d = idx_q + 1'b1;
                if (burst_q != BURST_C) begin
                    burst_d = burst_q + 1'b1;
                end
                // The count includes this cycle's issue, so a CPU slot follows
                // the BURST-th consecutive read.
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = cpu_pending ? ST_CPU_ISSUE : ST_IDLE;
                end else if (cpu_pending && (burst_q >= BURST_M1)) begin
                    state_d  = ST_CPU_ISSUE;
                    resume_d = 1'b1;
                end
            end
            ST_CPU_ISSUE: begin
                state_d = ST_CPU_ACK;
                if (line_start && !resume_q) begin
                    pend_d      = 1'b1;
                    pend_base_d = line_base;
                end
            end
            ST_CPU_ACK: begin
                if (resume_q) begin
                    state_d  = ST_FETCH;
                    burst_d  = '0;
                    resume_d = 1'b0;
                end else if (pend_q || line_start) begin
                    state_d = ST_FETCH;
                    base_d  = line_start ? line_base : pend_base_q;
                    idx_d   = '0;
                    burst_d = '0;
                    pend_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            pend_base_q <= '0;
            idx_q       <= '0;
            burst_q     <= '0;
            armed_q     <= 1'b1;
            pend_q      <= 1'b0;
            resume_q    <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_last_q   <= 1'b0;
            wr_idx_q    <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            pend_base_q <= pend_base_d;
            idx_q       <= idx_d;
            burst_q     <= burst_d;
            armed_q     <= armed_d;
            pend_q      <= pend_d;
            resume_q    <= resume_d;
            wr_valid_q  <= in_fetch;
            wr_last_q   <= in_fetch && (idx_q == LAST_IDX);
            wr_idx_q    <= idx_q;
        end
    end

    // Write-back trails each fetch issue by the SPRAM's one-cycle read latency.
    assign fetch_wr_en   = wr_valid_q;
    assign fetch_wr_idx  = wr_idx_q;
    assign fetch_wr_data = wr_valid_q ? mem_rdata : '0;
    assign fetch_done    = wr_valid_q && wr_last_q;
    assign fetch_overrun = line_start && fetch_busy;

    assign mem_cs     = in_fetch || in_issue;
    assign mem_we     = in_issue && cpu_we;
    assign mem_addr   = in_fetch ? (base_q + ADDR_W'(idx_q)) :
                        in_issue ? cpu_addr : '0;
    assign mem_wdata  = (in_issue && cpu_we) ? cpu_wdata : '0;
    assign mem_maskwe = in_issue ? {cpu_be[1], cpu_be[1], cpu_be[0], cpu_be[0]} : 4'b0000;

    assign cpu_ack   = (state_q == ST_CPU_ACK);
    assign cpu_rdata = (cpu_ack && !cpu_we) ? mem_rdata : '0;

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

- Shares the single-port video RAM (one iCE40UP5K SPRAM, 16-bit, 1-cycle read latency) between two requesters:
  - scanline fetch, which copies one line into the line buffer ahead of scanout;
  - the 68k bus interface.
- Sits between video_timing (`line_start` strobes), the line buffer, the CPU bus bridge and the SPRAM primitive.
- Scanline fetch has priority; CPU access latency is bounded by forced CPU slots between fetch bursts.

## Interface
- `ADDR_W`, 14: VRAM word address width.
- `DATA_W`, 16: VRAM word width.
- `FETCH_LEN`, 80: words fetched per scanline (1280 px at 16 px/word).
- `BURST`, 8: maximum consecutive fetch issues before a pending CPU access is granted a slot.
- `clk` in 1: pixel clock (74.25 MHz).
- `reset_n` in 1: asynchronous, active-low reset.
- `line_start` in 1: one-cycle strobe requesting a scanline fetch.
- `line_base` in ADDR_W: first word address of the line; sampled only when `line_start` is accepted.
- `fetch_wr_en` out 1: line-buffer write strobe.
- `fetch_wr_idx` out $clog2(FETCH_LEN): line-buffer write index.
- `fetch_wr_data` out DATA_W: line-buffer write data.
- `fetch_done` out 1: one-cycle pulse, coincident with the last `fetch_wr_en` of a line.
- `fetch_overrun` out 1: one-cycle pulse when `line_start` arrives while a fetch is active.
- `cpu_req` in 1: CPU access request; held high with stable address and data until `cpu_ack`.
- `cpu_we` in 1: 1 = write.
- `cpu_addr` in ADDR_W: CPU word address.
- `cpu_wdata` in DATA_W: CPU write data.
- `cpu_be` in 2: byte enables (UDS/LDS).
- `cpu_ack` out 1: one-cycle acknowledge.
- `cpu_rdata` out DATA_W: read data, valid only while `cpu_ack` is high.
- `mem_cs` out 1: SPRAM chip select.
- `mem_we` out 1: SPRAM write enable.
- `mem_addr` out ADDR_W: SPRAM address.
- `mem_wdata` out DATA_W: SPRAM write data.
- `mem_maskwe` out 4: SPRAM nibble write mask, expanded from `cpu_be`.
- `mem_rdata` in DATA_W: SPRAM read data.

## Operation
- States:
  - IDLE.
  - FETCH: one read issued per cycle.
  - CPU_ISSUE: `mem_cs` asserted with CPU address, data and write enable.
  - CPU_ACK: `cpu_ack` asserted; `cpu_rdata` is driven from `mem_rdata` for reads.
- IDLE transitions:
  - `line_start` → FETCH: latch `line_base`, clear the word index and the burst count.
  - otherwise, an armed `cpu_req` → CPU_ISSUE.
  - If both arrive in the same cycle, the fetch wins and the CPU request stays pending.
- FETCH issue and write-back:
  - Each cycle issue a read at `(base + idx) mod 2^ADDR_W`, then increment `idx` and the burst count.
  - Write-back is pipelined: a registered valid/index pair drives `fetch_wr_*` one cycle after each issue, including during CPU_ISSUE.
- FETCH exits:
  - Last word issued (`idx == FETCH_LEN-1`) → IDLE, or CPU_ISSUE if the CPU is armed and pending.
  - Burst count `== BURST` with the CPU armed and pending → CPU_ISSUE, with the resume flag set.
  - Without a pending CPU request, the burst count saturates and fetch continues.
- CPU_ISSUE always moves to CPU_ACK.
- CPU_ACK exits:
  - resume flag set → FETCH, with the burst count cleared;
  - else a pending latched `line_start` → FETCH;
  - else → IDLE.
- CPU arming:
  - `armed` clears on `cpu_ack`.
  - `armed` sets when `cpu_req` is sampled low.
  - This prevents the request still held during the ack cycle from being serviced twice.
- `line_start` handling:
  - During CPU_ISSUE or CPU_ACK with no fetch active: latch it as pending, with its `line_base`.
  - During FETCH, or with the resume flag set: pulse `fetch_overrun`, ignore the strobe, and let the current line continue.
- CPU reads and writes take identical state paths.
- `mem_maskwe` expansion: `{be[1],be[1],be[0],be[0]}`.

## Timing
- Reset (asynchronous, immediate):
  - all outputs 0, state IDLE, `armed` = 1, pending and resume flags cleared;
  - an in-flight fetch or CPU access is abandoned with no `fetch_done` and no `cpu_ack`.
- Fetch timing, for `line_start` sampled in cycle N from IDLE with no CPU activity:
  - reads issue in N+1 … N+FETCH_LEN;
  - `fetch_wr_en` is high in N+2 … N+FETCH_LEN+1;
  - `fetch_done` pulses in N+FETCH_LEN+1.
- CPU timing:
  - from IDLE: `cpu_req` in N → `mem_cs` in N+1 → `cpu_ack` in N+2;
  - worst case during a fetch: `cpu_ack` within BURST+2 cycles of an armed request;
  - each CPU slot stretches the fetch by exactly 2 cycles.
- `fetch_wr_idx` increments by 1 per write, 0 … FETCH_LEN-1, and never wraps within a line.
- Address arithmetic is modulo 2^ADDR_W; `line_base` near the top of VRAM wraps to 0.

## Structure
- Package `video_pkg` holds:
  - the state enum `vram_arb_state_t`;
  - the default constants `VRAM_ADDR_W`, `VRAM_DATA_W`, `LINE_WORDS`.
- Single module; no sub-module is warranted.
- Line buffer and SPRAM instances live in the parent.

## Test plan
- Fetch only: `line_start` with `line_base`=0x0100 → 80 writes, idx 0…79, data = memory model words 0x0100…0x014F, `fetch_done` coincident with idx 79.
- CPU write 0xBEEF to 0x2000 with `be`=2'b10, then read it back in IDLE → `mem_maskwe`=4'b1100, ack two cycles after each request, read returns 0xBE in the high byte with the low byte unchanged.
- CPU request raised during the third fetch word with BURST=8 → ack within 10 cycles, fetch completes with all 80 words correct, `fetch_done` delayed by 2 cycles.
- Simultaneous `line_start` and `cpu_req` in IDLE → fetch starts first, CPU acked after 8 words; `cpu_req` held 2 extra cycles after ack → exactly one access.
- Second `line_start` mid-fetch → `fetch_overrun` pulses, first line unaffected; `line_start` during CPU_ACK → fetch starts the next cycle.
- `reset_n` low mid-fetch at word 40 → outputs 0 that cycle, no `fetch_done`; after release, a new line fetches correctly.
